// File: rtl/cpu_bus_controller_if.sv
// CPU-side bus plus the PPU and cartridge ports of the CPU bus controller.
// The master modport is the CPU/peripheral side; the slave modport is the controller.
interface cpu_bus_controller_if;
    logic        cycle_start_i;
    logic [15:0] address_i;
    logic        bus_read_i;
    logic        bus_write_i;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        data_valid_o;

    logic [2:0]  ppu_address_o;
    logic [7:0]  ppu_data_o;
    logic        ppu_read_o;
    logic        ppu_write_o;
    logic [7:0]  ppu_data_i;
    logic        ppu_ack_i;

    logic [15:0] cart_address_o;
    logic [7:0]  cart_data_o;
    logic        cart_read_o;
    logic        cart_write_o;
    logic [7:0]  cart_data_i;
    logic        cart_ack_i;

    logic        bus_error_o;

    modport master (
        output cycle_start_i, address_i, bus_read_i, bus_write_i, data_i,
        output ppu_data_i, ppu_ack_i, cart_data_i, cart_ack_i,
        input  data_o, data_valid_o, bus_error_o,
        input  ppu_address_o, ppu_data_o, ppu_read_o, ppu_write_o,
        input  cart_address_o, cart_data_o, cart_read_o, cart_write_o
    );

    modport slave (
        input  cycle_start_i, address_i, bus_read_i, bus_write_i, data_i,
        input  ppu_data_i, ppu_ack_i, cart_data_i, cart_ack_i,
        output data_o, data_valid_o, bus_error_o,
        output ppu_address_o, ppu_data_o, ppu_read_o, ppu_write_o,
        output cart_address_o, cart_data_o, cart_read_o, cart_write_o
    );
endinterface

// File: rtl/cpu_bus_controller.sv
// CPU bus controller: decodes each CPU cycle to work RAM, PPU registers, I/O or cartridge,
// runs the external handshake with a timeout, and keeps an open-bus value for unmapped reads.
module cpu_bus_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RAM_DEPTH      = 2048
) (
    input logic                 clock_i,
    input logic                 reset_i,
    cpu_bus_controller_if.slave bus
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RAM, S_EXT_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {R_RAM, R_PPU, R_IO, R_CART} region_t;

    state_t        state, state_next;
    region_t       region;
    logic          start_pending;
    logic          req_read, req_write, start, accept;
    logic          ext_ack, timed_out;
    logic [7:0]    ext_rdata;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_idx;
    logic [7:0]    mem [RAM_DEPTH];
    logic [7:0]    ram_q;
    logic [7:0]    open_bus;
    logic [CW-1:0] timeout_cnt;
    logic          req_read_q, req_cart_q;

    assign ram_idx          = bus.address_i[AW-1:0];
    assign bus.data_valid_o = (state == S_DONE);

    always_comb begin
        region = R_CART;
        if (bus.address_i[15:13] == 3'b000)
            region = R_RAM;
        else if (bus.address_i[15:13] == 3'b001)
            region = R_PPU;
        else if (bus.address_i[15:5] == 11'h200)
            region = R_IO;
    end

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        req_read   = bus.bus_read_i;
        req_write  = bus.bus_write_i & ~bus.bus_read_i;
        start      = ((state == S_IDLE) && (bus.cycle_start_i || start_pending))
                  || ((state == S_DONE) && bus.cycle_start_i);
        accept     = start && (req_read || req_write);
        ext_ack    = req_cart_q ? bus.cart_ack_i  : bus.ppu_ack_i;
        ext_rdata  = req_cart_q ? bus.cart_data_i : bus.ppu_data_i;
        timed_out  = (timeout_cnt == TIMEOUT_LAST);
        ram_we     = accept && (region == R_RAM) && req_write && !reset_i;
        ram_re     = accept && (region == R_RAM) && req_read;
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    case (region)
                        R_RAM:   state_next = S_RAM;
                        R_IO:    state_next = S_DONE;
                        default: state_next = S_EXT_WAIT;
                    endcase
                end else if (start) begin
                    state_next = S_IDLE;
                end
            end
            S_RAM:      state_next = S_DONE;
            S_EXT_WAIT: if (ext_ack || timed_out) state_next = S_DONE;
            default:    state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= S_IDLE;
            start_pending <= 1'b1;
        end else begin
            state         <= state_next;
            start_pending <= 1'b0;
        end
    end

    // NOTE: the RAM array is deliberately not reset so it maps to block RAM and survives reset.
    always_ff @(posedge clock_i) begin
        if (ram_we)
            mem[ram_idx] <= bus.data_i;
        if (ram_re)
            ram_q <= mem[ram_idx];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            bus.data_o         <= '0;
            bus.bus_error_o    <= 1'b0;
            bus.ppu_address_o  <= '0;
            bus.ppu_data_o     <= '0;
            bus.ppu_read_o     <= 1'b0;
            bus.ppu_write_o    <= 1'b0;
            bus.cart_address_o <= '0;
            bus.cart_data_o    <= '0;
            bus.cart_read_o    <= 1'b0;
            bus.cart_write_o   <= 1'b0;
            open_bus           <= '0;
            timeout_cnt        <= '0;
            req_read_q         <= 1'b0;
            req_cart_q         <= 1'b0;
        end else if (accept) begin
            req_read_q  <= req_read;
            req_cart_q  <= (region == R_CART);
            timeout_cnt <= '0;
            if (req_write)
                open_bus <= bus.data_i;
            case (region)
                R_IO: begin
                    if (req_read)
                        bus.data_o <= open_bus;
                end
                R_PPU: begin
                    bus.ppu_address_o <= bus.address_i[2:0];
                    bus.ppu_data_o    <= bus.data_i;
                    bus.ppu_read_o    <= req_read;
                    bus.ppu_write_o   <= req_write;
                end
                R_CART: begin
                    bus.cart_address_o <= bus.address_i;
                    bus.cart_data_o    <= bus.data_i;
                    bus.cart_read_o    <= req_read;
                    bus.cart_write_o   <= req_write;
                end
                default: ;
            endcase
        end else if (state == S_RAM) begin
            if (req_read_q) begin
                bus.data_o <= ram_q;
                open_bus   <= ram_q;
            end
        end else if (state == S_EXT_WAIT) begin
            if (ext_ack || timed_out) begin
                bus.ppu_read_o   <= 1'b0;
                bus.ppu_write_o  <= 1'b0;
                bus.cart_read_o  <= 1'b0;
                bus.cart_write_o <= 1'b0;
                // An ack on the final timeout cycle still counts as a normal completion.
                if (ext_ack) begin
                    if (req_read_q) begin
                        bus.data_o <= ext_rdata;
                        open_bus   <= ext_rdata;
                    end
                end else begin
                    bus.bus_error_o <= 1'b1;
                    if (req_read_q)
                        bus.data_o <= open_bus;
                end
            end else begin
                timeout_cnt <= timeout_cnt + CW'(1);
            end
        end
    end
endmodule

// File: doc/cpu_bus_controller.md
CPU_BUS_CONTROLLER -- requirements
Module: cpu_bus_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of cycles to wait for an external ack before forcing completion.
REQ-002 Parameter RAM_DEPTH, default 2048, is the internal work-RAM size in bytes (address width 11).
REQ-003 clock_i  in  1  single clock; all logic on posedge.
REQ-004 reset_i  in  1  reset, synchronous, active-high.
REQ-005 cycle_start_i  in  1  one-cycle pulse marking the start of a new CPU bus cycle (CPU clock-enable tick).
REQ-006 address_i  in  16  CPU bus address.
REQ-007 bus_read_i / bus_write_i  in  1 each  CPU read/write request.
REQ-008 data_i  in  8  CPU write data.
REQ-009 data_o  out  8  read data returned to the CPU.
REQ-010 data_valid_o  out  1  high while data_o holds the completed result of the current bus cycle.
REQ-011 ppu_address_o  out  3, ppu_data_o  out  8, ppu_read_o / ppu_write_o  out  1: PPU register port.
REQ-012 ppu_data_i  in  8, ppu_ack_i  in  1: PPU response.
REQ-013 cart_address_o  out  16, cart_data_o  out  8, cart_read_o / cart_write_o  out  1: cartridge port.
REQ-014 cart_data_i  in  8, cart_ack_i  in  1: cartridge response.
REQ-015 bus_error_o  out  1  sticky flag, set on any timeout.

Function
REQ-016 Decode: $0000-$1FFF = RAM (index address_i[10:0], mirrored); $2000-$3FFF = PPU (register address_i[2:0], mirrored every 8); $4000-$401F = I/O (unimplemented); $4020-$FFFF = cartridge.
REQ-017 FSM states: IDLE, RAM, EXT_WAIT, DONE.
REQ-018 IDLE accepts a request only when a start is pending (cycle_start_i high, or the first cycle after reset) and bus_read_i or bus_write_i is high; otherwise it stays in IDLE with data_valid_o low.
REQ-019 If bus_read_i and bus_write_i are both high, the request is a read and the write is ignored.
REQ-020 RAM read: IDLE -> RAM (synchronous RAM read) -> DONE; data_valid_o is asserted 2 cycles after acceptance.
REQ-021 RAM write: the byte is written on the acceptance edge; the path then goes through RAM -> DONE with the same latency as a read; data_o is unchanged.
REQ-022 I/O region: IDLE -> DONE directly; a read returns the open-bus value; a write is discarded.
REQ-023 PPU/cart access: IDLE -> EXT_WAIT.
  - The selected port's read or write strobe and its address/data are registered high and held stable until ack.
  - On the ack edge: strobes drop, read data is latched into data_o, and the FSM goes to DONE.
REQ-024 Only one external strobe is high at any time; the strobes are never high outside EXT_WAIT.
REQ-025 Timeout:
  - A counter is cleared on entry to EXT_WAIT.
  - If it reaches TIMEOUT_CYCLES without ack: strobes drop, the access completes to DONE with the open-bus value, and bus_error_o is set.
REQ-026 An ack that arrives in the same cycle as the timeout is honoured as a normal completion; no error is flagged.
REQ-027 An ack that arrives outside EXT_WAIT is ignored.
REQ-028 DONE behaviour:
  - data_valid_o is high and data_o is held.
  - cycle_start_i clears data_valid_o and returns the FSM to IDLE.
  - A request present on that same cycle is accepted back-to-back.
REQ-029 cycle_start_i arriving in RAM or EXT_WAIT is ignored (the request is still in progress); the CPU stalls because data_valid_o is low.
REQ-030 Open-bus register: updated with every completed read result and every accepted write's data_i.
REQ-031 The request (address, data, type) is captured at acceptance; later changes on CPU inputs do not affect the transaction in flight.

Reset
REQ-032 Reset values:
  - FSM = IDLE with a start pending.
  - data_o = 0, data_valid_o = 0, bus_error_o = 0, open bus = 0.
  - All external strobes = 0; timeout counter = 0.
REQ-033 Reset mid-transaction drops all strobes on the next edge and abandons the access; RAM contents are not cleared.
REQ-034 bus_error_o is cleared only by reset.

Verification
REQ-035 Reset, then read $FFFC with cart_ack_i returned 3 cycles after cart_read_o rises and cart_data_i=$34 -> cart_address_o=$FFFC; data_o=$34; data_valid_o high the cycle after ack.
REQ-036 Write $5A to $0801, then read $1801 -> RAM index $001; data_o=$5A with data_valid_o 2 cycles after acceptance; no external strobes.
REQ-037 Read $200A with ppu_data_i=$80 and immediate ack -> ppu_address_o=2; ppu_read_o high 1 cycle; data_o=$80.
REQ-038 Read $8000 with no ack and TIMEOUT_CYCLES=4 -> strobe drops after 4 cycles; data_o equals the previous bus value; bus_error_o=1 and stays 1.
REQ-039 Read $4015 after a completed read of $A5 -> data_o=$A5, valid 1 cycle after acceptance.
REQ-040 Assert reset_i during EXT_WAIT, then ack -> strobes low the cycle after reset; the ack is ignored; data_valid_o=0.
